// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: one transaction per command
// (START, {addr, rw}, one data byte written or read, STOP).
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   cmd_start  one-cycle request, taken only while idle
//   cmd_addr   7-bit device address, latched on acceptance
//   cmd_rw     0 = write, 1 = read, latched on acceptance
//   cmd_wdata  write byte, latched on acceptance
//   busy       transaction in progress
//   done       one-cycle pulse when the transaction ends
//   ack_error  NACK seen in the last transaction (valid with done)
//   rx_data    last byte read, updated only by a read
//   scl        I2C clock, push-pull
//   sda        I2C data, open-drain (0 or 'z')
//
// Each bus slot has four quarters of QTR clocks. SCL is low in q0-q1 and
// high in q2-q3. SDA is updated at q0 and sampled on the last clock of q2.
// scl and the SDA enable are registered, so the bus pins trail the
// internal quarter counter by one clock.
module i2c_byte_master #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int I2C_FREQ_HZ = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_start,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic [7:0] rx_data,
  output logic       scl,
  inout  wire        sda
);

  // state      | meaning
  // S_IDLE     | bus idle, waiting for cmd_start
  // S_START    | SCL high, SDA falls at q2
  // S_ADDR     | 8 slots shifting {addr, rw}
  // S_ADDR_ACK | slave ACK of the address
  // S_WDATA    | 8 slots shifting the write byte
  // S_WDATA_ACK| slave ACK of the write byte
  // S_RDATA    | 8 slots sampling the read byte
  // S_RDATA_NACK| master NACKs the read byte
  // S_STOP     | SDA low q0-q2, released at q3
  // S_DONE     | one-cycle done pulse

  localparam int QTR = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

  // Slaves with a 3-flop synchroniser need at least 4 clocks per quarter.
  if (QTR < 4) begin : g_bad_qtr
    $error("i2c_byte_master: QTR=%0d must be at least 4", QTR);
  end

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WDATA_ACK,
    S_RDATA, S_RDATA_NACK, S_STOP, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr, rx_sr, wdata_q;
  logic          rw_q;
  logic          sda_meta, sda_sync, sda_smp;
  logic          sda_oe, sda_oe_nxt, scl_nxt;
  logic          qtr_end, slot_end, smp_pt, shift_state;

  assign qtr_end     = (qcnt == QW'(QTR - 1));
  assign slot_end    = qtr_end && (quarter == 2'd3);
  assign smp_pt      = qtr_end && (quarter == 2'd2);
  assign shift_state = (state == S_ADDR) || (state == S_WDATA) || (state == S_RDATA);

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);
  assign sda  = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      qcnt    <= '0;
      quarter <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE || state == S_DONE) begin
        qcnt    <= '0;
        quarter <= '0;
      end else if (qtr_end) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end
      if (slot_end && shift_state) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    scl_nxt    = 1'b1;
    sda_oe_nxt = 1'b0;
    case (state)
      S_IDLE: if (cmd_start) state_nxt = S_START;
      S_START: begin
        sda_oe_nxt = quarter[1];
        if (slot_end) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        scl_nxt    = quarter[1];
        sda_oe_nxt = ~tx_sr[7];
        if (slot_end && bit_cnt == 3'd7) state_nxt = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl_nxt = quarter[1];
        if (slot_end) begin
          if (sda_smp)   state_nxt = S_STOP;
          else if (rw_q) state_nxt = S_RDATA;
          else           state_nxt = S_WDATA;
        end
      end
      S_WDATA: begin
        scl_nxt    = quarter[1];
        sda_oe_nxt = ~tx_sr[7];
        if (slot_end && bit_cnt == 3'd7) state_nxt = S_WDATA_ACK;
      end
      S_WDATA_ACK: begin
        scl_nxt = quarter[1];
        if (slot_end) state_nxt = S_STOP;
      end
      S_RDATA: begin
        scl_nxt = quarter[1];
        if (slot_end && bit_cnt == 3'd7) state_nxt = S_RDATA_NACK;
      end
      S_RDATA_NACK: begin
        scl_nxt = quarter[1];
        if (slot_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        scl_nxt    = quarter[1];
        sda_oe_nxt = (quarter != 2'd3);
        if (slot_end) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl       <= 1'b1;
      sda_oe    <= 1'b0;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      sda_smp   <= 1'b1;
      tx_sr     <= '0;
      rx_sr     <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      ack_error <= 1'b0;
      rx_data   <= '0;
    end else begin
      scl      <= scl_nxt;
      sda_oe   <= sda_oe_nxt;
      sda_meta <= sda;
      sda_sync <= sda_meta;

      if (state == S_IDLE && cmd_start) begin
        tx_sr     <= {cmd_addr, cmd_rw};
        wdata_q   <= cmd_wdata;
        rw_q      <= cmd_rw;
        ack_error <= 1'b0;
      end

      if (smp_pt) begin
        sda_smp <= sda_sync;
        if (state == S_RDATA) rx_sr <= {rx_sr[6:0], sda_sync};
      end

      if (slot_end) begin
        case (state)
          S_ADDR, S_WDATA: tx_sr <= {tx_sr[6:0], 1'b0};
          S_ADDR_ACK: begin
            tx_sr <= wdata_q;
            if (sda_smp) ack_error <= 1'b1;
          end
          S_WDATA_ACK:  if (sda_smp) ack_error <= 1'b1;
          S_RDATA_NACK: rx_data <= rx_sr;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
module tb_i2c_byte_master;

  localparam int CLK_HZ = 2_000_000;
  localparam int I2C_HZ = 100_000;
  localparam int QTR    = CLK_HZ / (4 * I2C_HZ);
  localparam logic [6:0] SLV_ADDR = 7'h55;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_start = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic       busy, done, ack_error, scl;
  logic [7:0] rx_data;
  wire        sda;

  pullup (sda);

  i2c_byte_master #(.CLK_FREQ_HZ(CLK_HZ), .I2C_FREQ_HZ(I2C_HZ)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .busy(busy), .done(done),
    .ack_error(ack_error), .rx_data(rx_data), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- bus-level slave model (also the LED slave) -------------
  typedef enum int {PH_IDLE, PH_RX, PH_ACKP, PH_ACKS, PH_TX, PH_MACK} ph_t;

  logic       slv_oe = 1'b0;
  logic       slv_data_ack = 1'b1;
  logic [7:0] slv_rd_byte = 8'h00;
  logic [7:0] led = 8'h00;
  logic [7:0] bus_bytes [$];
  logic [7:0] shreg = '0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, s_scl, s_sda;
  logic       in_txn = 1'b0, match = 1'b0, is_rd = 1'b0, ack_now = 1'b0;
  logic       mack_last = 1'b0;
  ph_t        ph = PH_IDLE;
  int         bitn = 0, byte_no = 0;
  int         scl_rises = 0, stop_cnt = 0, mack_cnt = 0, done_cnt = 0;

  assign sda = slv_oe ? 1'b0 : 1'bz;

  always begin
    @(negedge clk);
    s_scl = scl;
    s_sda = sda;
    if (done === 1'b1) done_cnt++;
    if (prev_scl && s_scl && prev_sda && !s_sda) begin
      in_txn = 1'b1; ph = PH_RX; bitn = 0; byte_no = 0;
      shreg = '0; slv_oe = 1'b0; match = 1'b0;
    end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
      if (in_txn) stop_cnt++;
      in_txn = 1'b0; slv_oe = 1'b0; ph = PH_IDLE;
    end else if (!prev_scl && s_scl) begin
      scl_rises++;
      if (in_txn) begin
        case (ph)
          PH_RX: begin
            shreg = {shreg[6:0], s_sda};
            bitn++;
            if (bitn == 8) begin
              bus_bytes.push_back(shreg);
              if (byte_no == 0) begin
                match   = (shreg[7:1] == SLV_ADDR);
                is_rd   = shreg[0];
                ack_now = match;
              end else begin
                ack_now = match && slv_data_ack;
                if (ack_now) led = shreg;
              end
              ph = PH_ACKP;
            end
          end
          PH_TX: bitn++;
          PH_MACK: begin
            mack_last = s_sda;
            mack_cnt++;
            ph = PH_IDLE;
          end
          default: ;
        endcase
      end
    end else if (prev_scl && !s_scl && in_txn) begin
      case (ph)
        PH_ACKP: begin
          slv_oe = ack_now;
          ph = PH_ACKS;
        end
        PH_ACKS: begin
          slv_oe = 1'b0; bitn = 0; shreg = '0;
          if (byte_no == 0 && match) begin
            if (is_rd) begin
              ph = PH_TX;
              slv_oe = !slv_rd_byte[7];
            end else begin
              ph = PH_RX;
              byte_no = 1;
            end
          end else begin
            ph = PH_IDLE;
          end
        end
        PH_TX: begin
          if (bitn < 8) slv_oe = !slv_rd_byte[7 - bitn];
          else begin
            slv_oe = 1'b0;
            ph = PH_MACK;
          end
        end
        default: ;
      endcase
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  // ---------------- checking -----------------------------------------------
  int checks = 0;
  int failures = 0;
  logic [7:0] model_rx = 8'h00;
  logic [7:0] model_led = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                        input int pulse_at, output int ncyc, output logic err_d,
                        output logic [7:0] rx_d);
    int  t0;
    logic ok;
    @(negedge clk);
    cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_err_clear", 32'(ack_error), 32'd0);
    t0 = cyc;
    ok = 1'b0;
    err_d = 1'bx;
    rx_d = 'x;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        err_d = ack_error;
        rx_d = rx_data;
        break;
      end
      if (i == pulse_at) begin
        cmd_addr = 7'h23; cmd_rw = 1'b1; cmd_wdata = 8'h00; cmd_start = 1'b1;
      end else begin
        cmd_start = 1'b0;
      end
      @(negedge clk);
    end
    cmd_start = 1'b0;
    ncyc = cyc - t0;
    chk("done_seen", 32'(ok), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    #1;
  endtask

  task automatic run_and_check(input string tag, input logic [6:0] a, input logic rw,
                               input logic [7:0] wd, input logic [7:0] rd,
                               input logic dack, input int pulse_at);
    int b0, r0, s0, d0, m0, ncyc, exp_cyc, exp_nb;
    logic err_d, addr_ack, exp_err;
    logic [7:0] rx_d;
    slv_rd_byte = rd;
    slv_data_ack = dack;
    #1;
    b0 = bus_bytes.size(); r0 = scl_rises; s0 = stop_cnt; d0 = done_cnt; m0 = mack_cnt;

    addr_ack = (a == SLV_ADDR);
    exp_err  = !addr_ack || (!rw && !dack);
    exp_cyc  = (addr_ack ? 20 : 11) * 4 * QTR;
    exp_nb   = (addr_ack && !rw) ? 2 : 1;
    if (addr_ack && rw) model_rx = rd;
    if (addr_ack && !rw && dack) model_led = wd;

    do_txn(a, rw, wd, pulse_at, ncyc, err_d, rx_d);

    chk({tag, "_cycles"}, 32'(ncyc), 32'(exp_cyc));
    chk({tag, "_ack_error"}, 32'(err_d), 32'(exp_err));
    chk({tag, "_rx_data"}, 32'(rx_d), 32'(model_rx));
    chk({tag, "_nbytes"}, 32'(bus_bytes.size() - b0), 32'(exp_nb));
    if (bus_bytes.size() > b0)
      chk({tag, "_addr_byte"}, 32'(bus_bytes[b0]), 32'({a, rw}));
    if (exp_nb == 2 && bus_bytes.size() > b0 + 1)
      chk({tag, "_data_byte"}, 32'(bus_bytes[b0 + 1]), 32'(wd));
    chk({tag, "_scl_rises"}, 32'(scl_rises - r0), addr_ack ? 32'd19 : 32'd10);
    chk({tag, "_stop"}, 32'(stop_cnt - s0), 32'd1);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_led"}, 32'(led), 32'(model_led));
    if (addr_ack && rw) begin
      chk({tag, "_mack_cnt"}, 32'(mack_cnt - m0), 32'd1);
      chk({tag, "_mack_released"}, 32'(mack_last), 32'd1);
    end
  endtask

  initial begin
    int d_after;
    logic [6:0] ra;
    logic       rrw;

    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_error", 32'(ack_error), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_and_check("write", 7'h55, 1'b0, 8'hA5, 8'h00, 1'b1, -1);
    run_and_check("addr_nack", 7'h23, 1'b0, 8'h5A, 8'h00, 1'b1, -1);
    run_and_check("read", 7'h55, 1'b1, 8'h00, 8'h3C, 1'b1, -1);
    run_and_check("data_nack", 7'h55, 1'b0, 8'h5A, 8'h00, 1'b0, -1);

    run_and_check("busy_cmd", 7'h55, 1'b0, 8'h96, 8'h00, 1'b1, 100);
    d_after = done_cnt;
    repeat (50) @(negedge clk);
    chk("busy_cmd_idle", 32'(busy), 32'd0);
    chk("busy_cmd_no_extra_done", 32'(done_cnt), 32'(d_after));

    // Reset in the middle of write-data bit 3 (slot 13 after busy rises).
    slv_data_ack = 1'b1;
    @(negedge clk);
    cmd_addr = 7'h55; cmd_rw = 1'b0; cmd_wdata = 8'hA5; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (13 * 4 * QTR + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_scl", 32'(scl), 32'd1);
    chk("midrst_sda", 32'(sda), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'd0);
    model_rx = 8'h00;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_and_check("after_rst", 7'h55, 1'b0, 8'hC3, 8'h00, 1'b1, -1);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) ra = SLV_ADDR;
      else begin
        ra = 7'($urandom_range(0, 127));
        if (ra == SLV_ADDR) ra = 7'h23;
      end
      rrw = 1'($urandom_range(0, 1));
      run_and_check("rand", ra, rrw, 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
